// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter between two command requesters in front of a
// registered 8-bit ALU wrapper, with one command in flight at most.
// Ports:
//   clk, n_rst               clock, synchronous active-low reset
//   reqN_valid/reqN_ready    command handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op  operands and opcode (3'b111 is illegal)
//   rspN_valid/rspN_ready    response handshake for requester N
//   rspN_data, rspN_err      ALU result and illegal-opcode flag
//   alu_sig                  one-cycle load strobe to the ALU wrapper
//   alu_in_a/b, alu_control  latched operands and opcode to the ALU wrapper
//   alu_result               ALU result, valid the cycle after alu_sig
//   busy                     high whenever the FSM is not IDLE
module alu_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_err,
  output logic         alu_sig,
  output logic [W-1:0] alu_in_a,
  output logic [W-1:0] alu_in_b,
  output logic [2:0]   alu_control,
  input  logic [W-1:0] alu_result,
  output logic         busy
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  logic         last_grant;  // requester accepted most recently
  logic         cur_id;      // requester owning the in-flight command
  logic         grant0;
  logic         grant1;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_op;
  logic         rsp_hs;

  // Round-robin winner; ready is offered only in IDLE and never during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (n_rst && (state == IDLE)) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_a      = grant1 ? req1_a  : req0_a;
  assign sel_b      = grant1 ? req1_b  : req0_b;
  assign sel_op     = grant1 ? req1_op : req0_op;
  assign rsp_hs     = cur_id ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
  assign busy       = (state != IDLE);

  // FSM with registered ALU-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      alu_sig     <= 1'b0;
      alu_in_a    <= '0;
      alu_in_b    <= '0;
      alu_control <= 3'b000;
      rsp0_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_data   <= '0;
      rsp1_err    <= 1'b0;
    end else begin
      alu_sig <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cur_id      <= grant1;
            last_grant  <= grant1;
            alu_in_a    <= sel_a;
            alu_in_b    <= sel_b;
            alu_control <= sel_op;
            if (sel_op == OP_ILLEGAL) begin
              // Illegal opcode bypasses the ALU and answers with an error.
              state <= RESP;
              if (grant1) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= '0;
                rsp1_err   <= 1'b1;
              end else begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= '0;
                rsp0_err   <= 1'b1;
              end
            end else begin
              state   <= ISSUE;
              alu_sig <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // alu_result is valid now, one cycle after the strobe.
          state <= RESP;
          if (cur_id) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_result;
            rsp1_err   <= 1'b0;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_result;
            rsp0_err   <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            state      <= IDLE;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 8, operand/result width; fixed at 8 to match the 8-bit ALU datapath wrapper.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester n has a command.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's command this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-007 req0_op / req1_op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 arith right shift, 110 logical right shift, 111 illegal.
REQ-008 rsp0_valid / rsp1_valid  output  1  response for requester n present.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester n takes the response.
REQ-010 rsp0_data / rsp1_data  output  W  ALU result.
REQ-011 rsp0_err / rsp1_err  output  1  command had an illegal opcode.
REQ-012 alu_sig  output  1  load strobe to the registered ALU wrapper.
REQ-013 alu_in_a, alu_in_b  output  W  operands to the ALU wrapper.
REQ-014 alu_control  output  3  opcode to the ALU wrapper.
REQ-015 alu_result  input  W  registered ALU result; valid the cycle after alu_sig.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with one outstanding command at most.
REQ-018 In IDLE, reqN_ready SHALL be high only for the arbitration winner; a command is accepted when reqN_valid && reqN_ready.
REQ-019 Arbitration SHALL be round-robin: a sole valid requester wins; when both are valid, the requester not granted last wins; last_grant updates only on acceptance.
REQ-020 On acceptance, operands, op and requester id SHALL be latched; legal op -> ISSUE; op 111 -> RESP with data 8'h00, err 1, and no ALU strobe.
REQ-021 ISSUE SHALL last exactly one cycle, with alu_sig=1 and alu_in_a, alu_in_b and alu_control driven from the latched values; the next state is WAIT.
REQ-022 alu_sig SHALL be 0 in every other state; alu_in_a, alu_in_b and alu_control SHALL hold the latched values.
REQ-023 WAIT SHALL last one cycle, capture alu_result into the response register with err 0, and go to RESP.
REQ-024 In RESP, only the latched requester's rspN_valid SHALL be high; data and err are held stable until rspN_ready=1; on that handshake the FSM returns to IDLE.
REQ-025 Latency SHALL be as follows: legal op accepted at cycle T -> alu_sig at T+1 -> rsp_valid first high at T+3; illegal op -> rsp_valid at T+1.
REQ-026 No new command SHALL be accepted before the response handshake; the next acceptance comes no earlier than the cycle after it.
REQ-027 The arbiter SHALL not modify results; 8-bit wrap-around and shift semantics are those of the ALU.
REQ-028 The unselected rsp port SHALL drive valid 0, data 8'h00 and err 0.

Reset
REQ-029 When n_rst=0 at a rising clk edge, the state SHALL go to IDLE regardless of the current state, and any in-flight command or pending response is discarded.
REQ-030 Reset values SHALL be: every rspN_valid, rspN_data and rspN_err = 0; alu_sig, alu_in_a, alu_in_b and alu_control = 0; busy 0; reqN_ready 0 while n_rst=0.
REQ-031 last_grant SHALL reset to requester 1, so requester 0 wins the first contention.

Verification
REQ-032 req0 add 8'h05, 8'h03 alone at T -> alu_sig at T+1 with in_a=05, in_b=03, control=000; rsp0_valid at T+3, data 8'h08, err 0.
REQ-033 After reset, both valid: req0 sub 8'h10, 8'h01 and req1 and 8'hF0, 8'h3C -> req0 first, rsp0 8'h0F; req1 accepted in the first IDLE cycle after that, rsp1 8'h30.
REQ-034 req1 op 111 -> rsp1_valid at T+1, data 00, err 1; alu_sig stays 0 throughout.
REQ-035 rsp0_ready held low 5 cycles in RESP with req1_valid high -> rsp0_valid and data stable, req1_ready 0, busy 1 throughout.
REQ-036 n_rst pulsed low during WAIT -> next cycle IDLE, all rsp_valid 0, alu_sig 0; the next contention is won by req0.
REQ-037 req0 add 8'hFF, 8'h02 -> rsp0_data 8'h01, err 0.
